// File: rtl/rs232_pkg.sv
// Shared constants for the RS-232 transmit path: FSM encoding, frame length
// and default arbitration timing.
package rs232_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam int FRAME_BITS         = 12;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Round-robin successor of a requester index, wrapping at nreq.
    function automatic logic [2:0] next_ptr(input logic [2:0] id, input int nreq);
        return (id == 3'(nreq - 1)) ? 3'd0 : id + 3'd1;
    endfunction

endpackage

// File: rtl/rs232_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic            valid,
    output logic [2:0]      idx
);

    logic [7:0]      req_ext;
    logic [2:0]      cand [NREQ];
    logic [NREQ-1:0] hit;

    assign req_ext = 8'(req);

    // cand[gi] is the requester checked at priority offset gi from ptr.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [3:0] sum;
            assign sum       = {1'b0, ptr} + 4'(gi);
            assign cand[gi]  = (sum >= 4'(NREQ)) ? 3'(sum - 4'(NREQ)) : sum[2:0];
            assign hit[gi]   = req_ext[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid = |hit;
        idx   = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Round-robin sharing of one byte-serial RS-232 transmitter among NREQ
// producers, with an inter-frame gap and a grant-to-DONE watchdog.
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              CLK_TX,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [8*NREQ-1:0] REQ_DATA,
    output logic [NREQ-1:0]   ACK,
    output logic [7:0]        TX_DATA,
    output logic              TX_WR_EN,
    input  logic              TX_DONE,
    output logic              BUSY,
    output logic [2:0]        GRANT_ID,
    output logic              TIMEOUT_ERR
);

    localparam logic [7:0] WD_LAST     = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);
    localparam logic [1:0] AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    logic [1:0]      state_reg, state_next;
    logic [2:0]      rr_ptr_reg, rr_ptr_next;
    logic [7:0]      wd_cnt_reg, wd_cnt_next;
    logic [7:0]      gap_cnt_reg, gap_cnt_next;
    logic [NREQ-1:0] ack_reg, ack_next;
    logic [7:0]      tx_data_reg, tx_data_next;
    logic            wr_en_reg, wr_en_next;
    logic            busy_reg, busy_next;
    logic [2:0]      grant_reg, grant_next;
    logic            timeout_reg, timeout_next;

    logic            pick_valid;
    logic [2:0]      pick_idx;
    logic [7:0]      data_arr [8];
    logic [NREQ-1:0] grant_hot;
    logic            frame_end, wd_expire, release_now;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req   (REQ),
        .ptr   (rr_ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_data
            if (gi < NREQ) begin : g_used
                assign data_arr[gi] = REQ_DATA[gi*8 +: 8];
            end else begin : g_pad
                assign data_arr[gi] = 8'd0;
            end
        end
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
            assign grant_hot[gi] = (grant_reg == 3'(gi));
        end
    endgenerate

    // DONE takes priority over a watchdog expiry on the same cycle.
    assign frame_end   = (state_reg == SEND) && TX_DONE;
    assign wd_expire   = (state_reg == SEND) && !TX_DONE && (wd_cnt_reg == WD_LAST);
    assign release_now = frame_end || wd_expire;

    always_ff @(posedge CLK_TX) begin
        if (!RST) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= 3'd0;
            wd_cnt_reg  <= 8'd0;
            gap_cnt_reg <= 8'd0;
            ack_reg     <= '0;
            tx_data_reg <= 8'd0;
            wr_en_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            grant_reg   <= 3'd0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            wd_cnt_reg  <= wd_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            ack_reg     <= ack_next;
            tx_data_reg <= tx_data_next;
            wr_en_reg   <= wr_en_next;
            busy_reg    <= busy_next;
            grant_reg   <= grant_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_valid) state_next = SEND;
            SEND:    if (release_now) state_next = AFTER_FRAME;
            GAP:     if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_next  = rr_ptr_reg;
        wd_cnt_next  = wd_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        ack_next     = '0;
        tx_data_next = tx_data_reg;
        wr_en_next   = wr_en_reg;
        grant_next   = grant_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next   = pick_idx;
                    tx_data_next = data_arr[pick_idx];
                    wr_en_next   = 1'b1;
                    wd_cnt_next  = 8'd0;
                end
            end
            SEND: begin
                if (release_now) begin
                    wr_en_next   = 1'b0;
                    ack_next     = grant_hot;
                    rr_ptr_next  = next_ptr(grant_reg, NREQ);
                    gap_cnt_next = 8'd0;
                    timeout_next = wd_expire;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 8'd1;
                end
            end
            GAP:     gap_cnt_next = gap_cnt_reg + 8'd1;
            default: wr_en_next = 1'b0;
        endcase
        busy_next = (state_next != IDLE);
    end

    assign ACK         = ack_reg;
    assign TX_DATA     = tx_data_reg;
    assign TX_WR_EN    = wr_en_reg;
    assign BUSY        = busy_reg;
    assign GRANT_ID    = grant_reg;
    assign TIMEOUT_ERR = timeout_reg;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: single frame, round-robin order,
// pointer wrap, watchdog, DONE/timeout collision, stray DONE, reset mid-frame.
module tb_rs232_tx_arbiter;

    logic        CLK_TX = 1'b0;
    logic        RST = 1'b0;
    logic        TX_DONE = 1'b0;
    logic [3:0]  REQ = 4'd0;
    logic [31:0] REQ_DATA = 32'd0;
    logic [3:0]  ACK;
    logic [7:0]  TX_DATA;
    logic        TX_WR_EN;
    logic        BUSY;
    logic [2:0]  GRANT_ID;
    logic        TIMEOUT_ERR;

    int total = 0;
    int bad = 0;

    rs232_tx_arbiter #(.NREQ(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
        .CLK_TX      (CLK_TX),
        .RST         (RST),
        .REQ         (REQ),
        .REQ_DATA    (REQ_DATA),
        .ACK         (ACK),
        .TX_DATA     (TX_DATA),
        .TX_WR_EN    (TX_WR_EN),
        .TX_DONE     (TX_DONE),
        .BUSY        (BUSY),
        .GRANT_ID    (GRANT_ID),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 CLK_TX = ~CLK_TX;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK_TX);
    endtask

    // Entered one negedge after the grant edge; returns on the ACK negedge.
    task automatic serve(input logic [2:0] id, input logic [7:0] data);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << id;
        chk("wr_en_rise", 32'(TX_WR_EN), 32'd1);
        chk("tx_data", 32'(TX_DATA), 32'(data));
        chk("grant_id", 32'(GRANT_ID), 32'(id));
        chk("busy_send", 32'(BUSY), 32'd1);
        step(11);
        chk("tx_data_hold", 32'(TX_DATA), 32'(data));
        chk("wr_en_hold", 32'(TX_WR_EN), 32'd1);
        TX_DONE = 1'b1;
        step(1);
        TX_DONE = 1'b0;
        chk("ack_pulse", 32'(ACK), 32'(one_hot));
        chk("wr_en_drop", 32'(TX_WR_EN), 32'd0);
        chk("no_timeout", 32'(TIMEOUT_ERR), 32'd0);
        $display("frame grant=%0d data=%02h ack=%b", id, data, ACK);
    endtask

    // Two idle cycles between an ACK and the next write strobe.
    task automatic gap_idle();
        step(1);
        chk("ack_one_cycle", 32'(ACK), 32'd0);
        chk("gap1_wr_en", 32'(TX_WR_EN), 32'd0);
        step(1);
        chk("gap2_wr_en", 32'(TX_WR_EN), 32'd0);
        step(1);
    endtask

    logic [7:0] rr_bytes [4];

    initial begin
        rr_bytes[0] = 8'h11;
        rr_bytes[1] = 8'h22;
        rr_bytes[2] = 8'h33;
        rr_bytes[3] = 8'h44;

        // Reset state
        step(2);
        chk("rst_ack", 32'(ACK), 32'd0);
        chk("rst_tx_data", 32'(TX_DATA), 32'd0);
        chk("rst_wr_en", 32'(TX_WR_EN), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_grant", 32'(GRANT_ID), 32'd0);
        chk("rst_timeout", 32'(TIMEOUT_ERR), 32'd0);
        RST = 1'b1;
        step(1);

        // Single request
        REQ = 4'b0001;
        REQ_DATA = 32'h0000_00A5;
        step(1);
        serve(3'd0, 8'hA5);
        REQ = 4'b0000;
        step(1);
        chk("single_ack_clear", 32'(ACK), 32'd0);
        chk("single_busy_gap", 32'(BUSY), 32'd1);
        step(1);
        chk("single_busy_idle", 32'(BUSY), 32'd0);
        step(1);
        chk("single_no_regrant", 32'(TX_WR_EN), 32'd0);

        // Round-robin fairness from a fresh pointer
        RST = 1'b0;
        step(1);
        RST = 1'b1;
        REQ = 4'b1111;
        REQ_DATA = 32'h4433_2211;
        step(1);
        for (int i = 0; i < 5; i++) begin
            serve(3'(i % 4), rr_bytes[i % 4]);
            if (i == 4) REQ = 4'b1000;
            gap_idle();
        end

        // Pointer wrap: 3, then 1001 gives 0 then 3
        serve(3'd3, 8'h44);
        REQ = 4'b1001;
        gap_idle();
        serve(3'd0, 8'h11);
        REQ = 4'b1000;
        gap_idle();
        serve(3'd3, 8'h44);

        // Watchdog
        REQ = 4'b0100;
        gap_idle();
        chk("wd_grant", 32'(GRANT_ID), 32'd2);
        chk("wd_data", 32'(TX_DATA), 32'h33);
        step(63);
        chk("wd_still_sending", 32'(TX_WR_EN), 32'd1);
        chk("wd_no_early_err", 32'(TIMEOUT_ERR), 32'd0);
        chk("wd_no_early_ack", 32'(ACK), 32'd0);
        step(1);
        chk("wd_timeout_err", 32'(TIMEOUT_ERR), 32'd1);
        chk("wd_ack", 32'(ACK), 32'b0100);
        chk("wd_wr_en_drop", 32'(TX_WR_EN), 32'd0);
        $display("frame grant=2 aborted by watchdog ack=%b", ACK);
        REQ = 4'b0010;
        step(1);
        chk("wd_err_one_cycle", 32'(TIMEOUT_ERR), 32'd0);
        step(2);

        // DONE on the timeout cycle: ACK without TIMEOUT_ERR
        chk("col_wr_en", 32'(TX_WR_EN), 32'd1);
        chk("col_grant", 32'(GRANT_ID), 32'd1);
        chk("col_data", 32'(TX_DATA), 32'h22);
        step(63);
        TX_DONE = 1'b1;
        step(1);
        TX_DONE = 1'b0;
        chk("col_ack", 32'(ACK), 32'b0010);
        chk("col_no_timeout", 32'(TIMEOUT_ERR), 32'd0);
        chk("col_wr_en_drop", 32'(TX_WR_EN), 32'd0);
        $display("frame grant=1 done on timeout cycle ack=%b", ACK);

        // Stray DONE in GAP, then in IDLE
        REQ = 4'b0000;
        TX_DONE = 1'b1;
        step(1);
        TX_DONE = 1'b0;
        chk("stray_gap_ack", 32'(ACK), 32'd0);
        chk("stray_gap_busy", 32'(BUSY), 32'd1);
        step(1);
        chk("stray_gap_len", 32'(BUSY), 32'd0);
        TX_DONE = 1'b1;
        step(1);
        TX_DONE = 1'b0;
        chk("stray_idle_ack", 32'(ACK), 32'd0);
        chk("stray_idle_busy", 32'(BUSY), 32'd0);
        chk("stray_idle_wr_en", 32'(TX_WR_EN), 32'd0);
        chk("stray_idle_err", 32'(TIMEOUT_ERR), 32'd0);

        // Reset mid-SEND; pointer (now 2) returns to 0
        REQ = 4'b0101;
        step(1);
        chk("pre_rst_grant", 32'(GRANT_ID), 32'd2);
        chk("pre_rst_data", 32'(TX_DATA), 32'h33);
        step(5);
        RST = 1'b0;
        step(1);
        chk("mid_rst_ack", 32'(ACK), 32'd0);
        chk("mid_rst_wr_en", 32'(TX_WR_EN), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        chk("mid_rst_grant", 32'(GRANT_ID), 32'd0);
        chk("mid_rst_data", 32'(TX_DATA), 32'd0);
        chk("mid_rst_err", 32'(TIMEOUT_ERR), 32'd0);
        RST = 1'b1;
        step(1);
        serve(3'd0, 8'h11);
        REQ = 4'b0100;
        gap_idle();
        serve(3'd2, 8'h33);
        REQ = 4'b0000;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
